alu_status_flags: RTL and testbench

//  Registered NZCV status-flag unit for the ALU datapath, parametrised in width.

---
 rtl/alu_status_flags.sv | 111 +++++++++++
 tb/tb_alu_status_flags.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_status_flags.sv
// Registered NZCV status flags for add/sub/adc/sbc, with sticky overflow (Q)
// and a saturating count of signed-overflow events.
module alu_status_flags #(
  parameter int BITS  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       op,
  input  logic [BITS-1:0]  a,
  input  logic [BITS-1:0]  b,
  input  logic [BITS-1:0]  result,
  input  logic             set_flags,
  input  logic             q_clr,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_q,
  output logic [CNT_W-1:0] ovf_count,
  output logic             out_valid
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             r_n;
  logic             r_z;
  logic             r_c;
  logic             r_v;
  logic             r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;

  logic            w_is_arith;
  logic            w_is_sub;
  logic            w_use_cin;
  logic            w_cin;
  logic [BITS-1:0] w_b_op;
  logic [BITS:0]   w_sum;
  logic            w_c;
  logic            w_sa;
  logic            w_sb;
  logic            w_sr;
  logic            w_v;
  logic            w_load;
  logic            w_v_event;

  // op[3:2]==0 selects the arithmetic group; op[0] is subtract, op[1] chains the old carry.
  assign w_is_arith = (op[3:2] == 2'b00);
  assign w_is_sub   = op[0];
  assign w_use_cin  = op[1];
  assign w_cin      = w_use_cin ? r_c : w_is_sub;
  assign w_b_op     = w_is_sub ? ~b : b;
  assign w_sum      = {1'b0, a} + {1'b0, w_b_op} + {{BITS{1'b0}}, w_cin};
  assign w_c        = w_sum[BITS];

  assign w_sa = a[BITS-1];
  assign w_sb = b[BITS-1];
  assign w_sr = result[BITS-1];
  assign w_v  = w_is_sub ? ((w_sa ^ w_sb) & (w_sa ^ w_sr))
                         : (~(w_sa ^ w_sb) & (w_sa ^ w_sr));

  assign w_load    = in_valid & set_flags;
  assign w_v_event = in_valid & w_is_arith & w_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_q         <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;

      if (w_load) begin
        r_n <= result[BITS-1];
        r_z <= (result == '0);
        if (w_is_arith) begin
          r_c <= w_c;
          r_v <= w_v;
        end
      end

      // A new overflow event takes priority over a simultaneous clear.
      if (w_v_event) begin
        r_q <= 1'b1;
      end else if (q_clr) begin
        r_q <= 1'b0;
      end

      if (q_clr) begin
        r_cnt <= w_v_event ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      end else if (w_v_event && (r_cnt != CntMax)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign flag_n    = r_n;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign flag_q    = r_q;
  assign ovf_count = r_cnt;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_status_flags.sv
// Directed vector bench for alu_status_flags (BITS=32, CNT_W=2 so saturation is reachable).
module tb_alu_status_flags;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] ADC = 4'b0010;
  localparam logic [3:0] SBC = 4'b0011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  op = 4'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result = '0;
  logic        set_flags = 1'b0;
  logic        q_clr = 1'b0;
  logic        flag_n, flag_z, flag_c, flag_v, flag_q, out_valid;
  logic [1:0]  ovf_count;

  int total = 0;
  int bad = 0;

  alu_status_flags #(.BITS(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
    .a(a), .b(b), .result(result), .set_flags(set_flags), .q_clr(q_clr),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .flag_q(flag_q), .ovf_count(ovf_count), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        iv;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        sf;
    logic        qc;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  // Expected output packing: {out_valid, N, Z, C, V, Q, count[1:0]}.
  function automatic logic [7:0] pk(logic ov, logic n, logic z, logic c,
                                    logic v, logic q, logic [1:0] cnt);
    return {ov, n, z, c, v, q, cnt};
  endfunction

  function automatic vec_t mk(string name, logic iv, logic [3:0] o, logic [31:0] va,
                              logic [31:0] vb, logic [31:0] vr, logic sf, logic qc,
                              logic [7:0] e);
    vec_t t;
    t.name = name; t.iv = iv; t.op = o; t.a = va; t.b = vb; t.res = vr;
    t.sf = sf; t.qc = qc; t.exp = e;
    return t;
  endfunction

  task automatic applyStimulus(input logic iv, input logic [3:0] o, input logic [31:0] va,
                               input logic [31:0] vb, input logic [31:0] vr,
                               input logic sf, input logic qc);
    in_valid = iv; op = o; a = va; b = vb; result = vr; set_flags = sf; q_clr = qc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {out_valid, flag_n, flag_z, flag_c, flag_v, flag_q, ovf_count};
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got ov/n/z/c/v/q/cnt=%b want %b", name, got, exp);
    end
  endtask

  initial begin
    logic [1:0] satExp [5];
    satExp[0] = 2'd1; satExp[1] = 2'd2; satExp[2] = 2'd3; satExp[3] = 2'd3; satExp[4] = 2'd3;

    vecs.push_back(mk("add_ovf",      1, ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0, pk(1,1,0,0,1,1,1)));
    vecs.push_back(mk("sub_ovf",      1, SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0, pk(1,0,0,1,1,1,2)));
    vecs.push_back(mk("sub_equal",    1, SUB, 32'h5, 32'h5, 32'h0, 1, 0, pk(1,0,1,1,0,1,2)));
    vecs.push_back(mk("adc_cin1",     1, ADC, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 0, pk(1,0,1,1,0,1,2)));
    vecs.push_back(mk("adc_noset",    1, ADC, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0, pk(1,0,1,1,0,1,2)));
    vecs.push_back(mk("add_ovf_noset",1, ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, pk(1,0,1,1,0,1,3)));
    vecs.push_back(mk("sub_ovf_sat",  1, SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0, pk(1,0,0,1,1,1,3)));
    vecs.push_back(mk("logic_zero",   1, 4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1, 0, pk(1,0,1,1,1,1,3)));
    vecs.push_back(mk("logic_neg",    1, 4'b1111, 32'h0, 32'h0, 32'h80000000, 1, 0, pk(1,1,0,1,1,1,3)));
    vecs.push_back(mk("idle",         0, ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0, pk(0,1,0,1,1,1,3)));
    vecs.push_back(mk("add_small",    1, ADD, 32'h1, 32'h1, 32'h2, 1, 0, pk(1,0,0,0,0,1,3)));
    vecs.push_back(mk("sbc_cin0",     1, SBC, 32'h0, 32'h0, 32'hFFFFFFFF, 1, 0, pk(1,1,0,0,0,1,3)));
    vecs.push_back(mk("sub_set_c",    1, SUB, 32'h5, 32'h5, 32'h0, 1, 0, pk(1,0,1,1,0,1,3)));
    vecs.push_back(mk("sbc_cin1",     1, SBC, 32'h0, 32'h0, 32'h0, 1, 0, pk(1,0,1,1,0,1,3)));
    vecs.push_back(mk("add_clr_c",    1, ADD, 32'h1, 32'h1, 32'h2, 1, 0, pk(1,0,0,0,0,1,3)));
    vecs.push_back(mk("adc_cin0",     1, ADC, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1, 0, pk(1,1,0,0,0,1,3)));
    vecs.push_back(mk("sbc_ovf",      1, SBC, 32'h80000000, 32'h0, 32'h7FFFFFFF, 1, 0, pk(1,0,0,1,1,1,3)));

    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", pk(0,0,0,0,0,0,0));
    applyStimulus(1, ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0);
    tick();
    checkOutput("reset_held", pk(0,0,0,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].iv, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                    vecs[i].sf, vecs[i].qc);
      tick();
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Counter clear, saturation, and clear/event collision.
    applyStimulus(1, ADD, 32'h1, 32'h1, 32'h2, 1, 1);
    tick();
    checkOutput("qclr_from_sat", pk(1,0,0,0,0,0,0));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0);
      tick();
      checkOutput($sformatf("sat_event_%0d", i), pk(1,1,0,0,1,1,satExp[i]));
    end
    applyStimulus(1, ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 1);
    tick();
    checkOutput("event_with_qclr", pk(1,1,0,0,1,1,1));
    applyStimulus(1, ADD, 32'h1, 32'h1, 32'h2, 1, 1);
    tick();
    checkOutput("qclr_alone", pk(1,0,0,0,0,0,0));

    // Asynchronous reset between edges with an op in flight.
    applyStimulus(1, ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0);
    tick();
    checkOutput("pre_reset_op", pk(1,1,0,0,1,1,1));
    applyStimulus(1, SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_async", pk(0,0,0,0,0,0,0));
    tick();
    checkOutput("mid_reset_discard", pk(0,0,0,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0);
    tick();
    checkOutput("first_after_reset", pk(1,0,0,1,1,1,1));
    applyStimulus(0, ADD, 32'h0, 32'h0, 32'h0, 0, 0);
    tick();
    checkOutput("idle_after_reset", pk(0,0,0,1,1,1,1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
